// File: rtl/axis_adc_decimator.sv
// rtl/axis_adc_decimator.sv - power-of-two block-average decimator for a signed ADC sample stream
module axis_adc_decimator #(
    parameter int ADC_WIDTH         = 14,
    parameter int S_AXIS_DATA_WIDTH = 16,
    parameter int M_AXIS_DATA_WIDTH = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    input  logic [1:0]                   dec_log2,
    input  logic                         resync,
    input  logic                         ovr_clear,
    output logic [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic                         ovr,
    output logic [2:0]                   dbg_count
);

    // Three guard bits hold the sum of up to eight full-scale samples.
    localparam int ACC_W = ADC_WIDTH + 3;

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] scaled;
    logic [2:0]              count;
    logic [2:0]              cur_count;
    logic [2:0]              last_idx;
    logic [1:0]              n_reg;
    logic [1:0]              n_eff;
    logic                    start;
    logic                    done;
    logic                    rail;
    logic                    unused_bits;

    assign x = {{3{S_AXIS_tdata[ADC_WIDTH-1]}}, S_AXIS_tdata[ADC_WIDTH-1:0]};
    assign rail = (S_AXIS_tdata[ADC_WIDTH-1:0] == {1'b0, {(ADC_WIDTH-1){1'b1}}}) ||
                  (S_AXIS_tdata[ADC_WIDTH-1:0] == {1'b1, {(ADC_WIDTH-1){1'b0}}});

    // A resync makes this cycle's sample the first of a fresh block.
    assign cur_count = resync ? 3'd0 : count;
    assign start     = (cur_count == 3'd0);
    assign n_eff     = start ? dec_log2 : n_reg;
    assign sum       = start ? x : acc + x;
    assign rounded   = sum + ACC_W'(1);
    assign done      = S_AXIS_tvalid && (cur_count == last_idx);
    assign dbg_count = count;

    always_comb begin
        last_idx = 3'd0;
        scaled   = sum;
        case (n_eff)
            2'd0: begin last_idx = 3'd0; scaled = sum <<< 2;     end
            2'd1: begin last_idx = 3'd1; scaled = sum <<< 1;     end
            2'd2: begin last_idx = 3'd3; scaled = sum;           end
            2'd3: begin last_idx = 3'd7; scaled = rounded >>> 1; end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count         <= 3'd0;
            acc           <= '0;
            n_reg         <= 2'd2;
            ovr           <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
        end else begin
            M_AXIS_tvalid <= done;
            if (S_AXIS_tvalid) begin
                acc   <= sum;
                count <= done ? 3'd0 : cur_count + 3'd1;
                if (start)
                    n_reg <= dec_log2;
            end else if (resync) begin
                count <= 3'd0;
            end
            if (done)
                M_AXIS_tdata <= scaled[M_AXIS_DATA_WIDTH-1:0];
            if (S_AXIS_tvalid && rail)
                ovr <= 1'b1;
            else if (ovr_clear)
                ovr <= 1'b0;
        end
    end

    assign unused_bits = &{1'b0, S_AXIS_tdata[S_AXIS_DATA_WIDTH-1:ADC_WIDTH],
                           scaled[ACC_W-1:M_AXIS_DATA_WIDTH]};

endmodule

// File: tb/tb_axis_adc_decimator.sv
// tb/tb_axis_adc_decimator.sv - directed self-checking bench for axis_adc_decimator
module tb_axis_adc_decimator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic [1:0]  dec_log2;
    logic        resync;
    logic        ovr_clear;
    logic [15:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        ovr;
    logic [2:0]  dbg_count;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_adc_decimator dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .dec_log2      (dec_log2),
        .resync        (resync),
        .ovr_clear     (ovr_clear),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .ovr           (ovr),
        .dbg_count     (dbg_count)
    );

    // Called at a falling edge; applies inputs across one rising edge and returns at the next falling edge.
    task automatic drive(input logic v, input logic [15:0] d);
        S_AXIS_tvalid = v;
        S_AXIS_tdata  = d;
        @(negedge aclk);
        S_AXIS_tvalid = 1'b0;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (M_AXIS_tdata !== 16'd0) begin errors++; $display("FAIL reset_tdata got %0d want 0", M_AXIS_tdata); end
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", M_AXIS_tvalid); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dbg_count); end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_basic;
        logic [15:0] xs [4];
        xs[0] = 16'hC064; xs[1] = 16'd200; xs[2] = 16'h812C; xs[3] = 16'd400;
        dec_log2 = 2'd2;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, xs[i]);
            checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL basic_nopulse[%0d] got %b want 0", i, M_AXIS_tvalid); end
            checks++; if (dbg_count !== 3'(i + 1)) begin errors++; $display("FAIL basic_count[%0d] got %0d want %0d", i, dbg_count, i + 1); end
        end
        drive(1'b1, xs[3]);
        checks++; if (M_AXIS_tvalid !== 1'b1) begin errors++; $display("FAIL basic_pulse got %b want 1", M_AXIS_tvalid); end
        checks++; if (M_AXIS_tdata !== 16'd1000) begin errors++; $display("FAIL basic_tdata got %0d want 1000", $signed(M_AXIS_tdata)); end
        checks++; if (dbg_count !== 3'd0) begin errors++; $display("FAIL basic_count_wrap got %0d want 0", dbg_count); end
        drive(1'b0, 16'd0);
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %b want 0", M_AXIS_tvalid); end
        checks++; if (M_AXIS_tdata !== 16'd1000) begin errors++; $display("FAIL basic_hold got %0d want 1000", $signed(M_AXIS_tdata)); end
    endtask

    task automatic test_rails;
        dec_log2 = 2'd3;
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h1FFF);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd32764) begin errors++; $display("FAIL rail_pos got v=%b %0d want v=1 32764", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL rail_ovr_set got %b want 1", ovr); end
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h2000);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'h8000) begin errors++; $display("FAIL rail_neg got v=%b %0d want v=1 -32768", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
        ovr_clear = 1'b1;
        drive(1'b0, 16'd0);
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ovr); end
        drive(1'b1, 16'h1FFF);
        ovr_clear = 1'b0;
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b want 1", ovr); end
        resync = 1'b1;
        drive(1'b0, 16'd0);
        resync = 1'b0;
        checks++; if (dbg_count !== 3'd0 || M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL resync_idle got count=%0d v=%b want 0 0", dbg_count, M_AXIS_tvalid); end
    endtask

    task automatic test_n1;
        dec_log2 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hFFFD);
            checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'hFFF4) begin errors++; $display("FAIL n1_pulse[%0d] got v=%b %0d want v=1 -12", i, M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
            drive(1'b0, 16'd0);
            checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL n1_gap[%0d] got %b want 0", i, M_AXIS_tvalid); end
        end
    endtask

    task automatic test_gaps;
        dec_log2 = 2'd1;
        drive(1'b1, 16'd5);
        dec_log2 = 2'd2;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'd0);
            checks++; if (M_AXIS_tvalid !== 1'b0 || dbg_count !== 3'd1) begin errors++; $display("FAIL gap_hold[%0d] got v=%b count=%0d want v=0 count=1", i, M_AXIS_tvalid, dbg_count); end
        end
        drive(1'b1, 16'd7);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd24) begin errors++; $display("FAIL gap_n2 got v=%b %0d want v=1 24", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd1);
        checks++; if (M_AXIS_tvalid !== 1'b0 || dbg_count !== 3'd2) begin errors++; $display("FAIL gap_next_n4 got v=%b count=%0d want v=0 count=2", M_AXIS_tvalid, dbg_count); end
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd1);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd4) begin errors++; $display("FAIL gap_n4_out got v=%b %0d want v=1 4", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
    endtask

    task automatic test_back_to_back;
        dec_log2 = 2'd1;
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd2);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd6) begin errors++; $display("FAIL b2b_first got v=%b %0d want v=1 6", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
        drive(1'b1, 16'd3);
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_mid got %b want 0", M_AXIS_tvalid); end
        drive(1'b1, 16'd4);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd14) begin errors++; $display("FAIL b2b_second got v=%b %0d want v=1 14", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
    endtask

    task automatic test_resync;
        dec_log2 = 2'd2;
        drive(1'b1, 16'd10);
        drive(1'b1, 16'd10);
        checks++; if (dbg_count !== 3'd2) begin errors++; $display("FAIL resync_pre got %0d want 2", dbg_count); end
        resync = 1'b1;
        drive(1'b1, 16'd1);
        resync = 1'b0;
        checks++; if (M_AXIS_tvalid !== 1'b0 || dbg_count !== 3'd1) begin errors++; $display("FAIL resync_restart got v=%b count=%0d want v=0 count=1", M_AXIS_tvalid, dbg_count); end
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd1);
        checks++; if (M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL resync_nopulse got %b want 0", M_AXIS_tvalid); end
        drive(1'b1, 16'd1);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd4) begin errors++; $display("FAIL resync_out got v=%b %0d want v=1 4", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
    endtask

    task automatic test_reset_mid;
        dec_log2 = 2'd2;
        drive(1'b1, 16'd50);
        drive(1'b1, 16'd50);
        aresetn = 1'b0;
        #1;
        checks++; if (M_AXIS_tdata !== 16'd0 || M_AXIS_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_out got v=%b %0d want v=0 0", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
        checks++; if (ovr !== 1'b0 || dbg_count !== 3'd0) begin errors++; $display("FAIL rstmid_state got ovr=%b count=%0d want 0 0", ovr, dbg_count); end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 16'd50);
        checks++; if (M_AXIS_tvalid !== 1'b0 || dbg_count !== 3'd3) begin errors++; $display("FAIL rstmid_partial got v=%b count=%0d want v=0 count=3", M_AXIS_tvalid, dbg_count); end
        drive(1'b1, 16'd50);
        checks++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 16'd200) begin errors++; $display("FAIL rstmid_out2 got v=%b %0d want v=1 200", M_AXIS_tvalid, $signed(M_AXIS_tdata)); end
    endtask

    initial begin
        aresetn       = 1'b0;
        S_AXIS_tdata  = 16'd0;
        S_AXIS_tvalid = 1'b0;
        dec_log2      = 2'd2;
        resync        = 1'b0;
        ovr_clear     = 1'b0;
        @(negedge aclk);
        test_reset;
        test_basic;
        test_rails;
        test_n1;
        test_gaps;
        test_back_to_back;
        test_resync;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
